// File: rtl/axi4_lite_traffic_gen_pkg.sv
// Shared types and constants for the AXI4-Lite traffic generator.
// Holds the FSM state enum, default parameters, and LFSR seeds/taps.
package axi4_lite_traffic_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_DATA,
    WR_WAIT,
    RD_REQ,
    RD_DATA,
    DONE
  } tg_state_e;

  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_LEN_WIDTH     = 5;
  localparam int DEF_MAX_LEN       = 16;
  localparam int DEF_NUM_BURSTS    = 16;
  localparam int DEF_TIMEOUT       = 255;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] DATA_SEED = 32'hACE1_2468;
  localparam logic [31:0] ADDR_SEED = 32'h1357_9BDF;

endpackage

// File: rtl/axi4_lite_traffic_gen_lfsr_gen.sv
// Parametrised Galois LFSR with synchronous load and advance enable.
// Ports: clock, active-low sync reset, load/load_val, en, q (state).
module lfsr_gen #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             axi4_lite_aclk,
  input  logic             axi4_lite_aresetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge axi4_lite_aclk) begin
    if (!axi4_lite_aresetn) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/axi4_lite_traffic_gen.sv
// Write-then-read-back traffic generator for a simple AXI4-Lite master.
// Ports: start/addr_mode/len_mode in; WRITE/READ/CPU_ADDR/DATA_* out;
// DATA_OUT/OUT_VALID/BUSY in; done/pass/timeout/error_count status.
module axi4_lite_traffic_gen
  import axi4_lite_traffic_gen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int MAX_LEN       = DEF_MAX_LEN,
  parameter int NUM_BURSTS    = DEF_NUM_BURSTS,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                     axi4_lite_aclk,
  input  logic                     axi4_lite_aresetn,
  input  logic                     start,
  input  logic                     addr_mode,
  input  logic                     len_mode,
  output logic                     WRITE,
  output logic                     READ,
  output logic [ADDRESS_WIDTH-1:0] CPU_ADDR,
  output logic [LEN_WIDTH-1:0]     DATA_LENGTH,
  output logic [DATA_WIDTH-1:0]    DATA_IN,
  output logic                     DATA_VALID,
  input  logic [DATA_WIDTH-1:0]    DATA_OUT,
  input  logic                     OUT_VALID,
  input  logic                     BUSY,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [15:0]              error_count
);

  tg_state_e state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] seq_addr;
  logic [LEN_WIDTH-1:0]     cyc_len;
  logic [LEN_WIDTH-1:0]     beat_cnt;
  logic [15:0]              burst_cnt;
  logic [15:0]              wait_cnt;
  logic [DATA_WIDTH-1:0]    seed_q;
  logic                     seen_busy;
  logic                     amode_q;
  logic                     lmode_q;

  logic [DATA_WIDTH-1:0]    d_q;
  logic [ADDRESS_WIDTH-1:0] a_q;

  logic fire_wr, fire_rd, wr_beat, rd_beat;
  logic pair_done, to_hit, mismatch, progress;
  logic start_take, idle_lim, last_burst;

  assign idle_lim   = (wait_cnt == 16'(TIMEOUT - 1));
  assign last_burst = (burst_cnt == 16'(NUM_BURSTS - 1));
  assign start_take = start && (state == IDLE || state == DONE);
  assign mismatch   = rd_beat && (DATA_OUT != d_q);
  // A wait state is idle while it neither moves on nor takes a beat.
  assign progress   = (state_nxt != state) || rd_beat;

  lfsr_gen #(
    .WIDTH(DATA_WIDTH),
    .TAPS (DATA_WIDTH'(LFSR_TAPS)),
    .SEED (DATA_WIDTH'(DATA_SEED))
  ) u_data_lfsr (
    .axi4_lite_aclk   (axi4_lite_aclk),
    .axi4_lite_aresetn(axi4_lite_aresetn),
    .load             (fire_rd),
    .load_val         (seed_q),
    .en               (fire_wr || wr_beat || rd_beat),
    .q                (d_q)
  );

  lfsr_gen #(
    .WIDTH(ADDRESS_WIDTH),
    .TAPS (ADDRESS_WIDTH'(LFSR_TAPS)),
    .SEED (ADDRESS_WIDTH'(ADDR_SEED))
  ) u_addr_lfsr (
    .axi4_lite_aclk   (axi4_lite_aclk),
    .axi4_lite_aresetn(axi4_lite_aresetn),
    .load             (1'b0),
    .load_val         ('0),
    .en               (fire_wr && amode_q),
    .q                (a_q)
  );

  always_ff @(posedge axi4_lite_aclk) begin
    if (!axi4_lite_aresetn) state <= IDLE;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fire_wr   = 1'b0;
    fire_rd   = 1'b0;
    wr_beat   = 1'b0;
    rd_beat   = 1'b0;
    pair_done = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = WR_REQ;
      end
      WR_REQ: begin
        if (!BUSY) begin
          fire_wr   = 1'b1;
          state_nxt = WR_DATA;
        end else if (idle_lim) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      WR_DATA: begin
        if (beat_cnt < DATA_LENGTH) wr_beat = 1'b1;
        else                        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (seen_busy && !BUSY) begin
          state_nxt = RD_REQ;
        end else if (idle_lim) begin
          // Never-busy masters are let through; a stuck one is an error.
          if (seen_busy || BUSY) begin
            to_hit    = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!BUSY) begin
          fire_rd   = 1'b1;
          state_nxt = RD_DATA;
        end else if (idle_lim) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      RD_DATA: begin
        if (OUT_VALID) begin
          rd_beat = 1'b1;
          if (beat_cnt == DATA_LENGTH - LEN_WIDTH'(1)) begin
            pair_done = 1'b1;
            state_nxt = last_burst ? DONE : WR_REQ;
          end
        end else if (idle_lim) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi4_lite_aclk) begin
    if (!axi4_lite_aresetn) begin
      WRITE       <= 1'b0;
      READ        <= 1'b0;
      CPU_ADDR    <= '0;
      DATA_LENGTH <= '0;
      DATA_IN     <= '0;
      DATA_VALID  <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      error_count <= '0;
      seq_addr    <= '0;
      cyc_len     <= LEN_WIDTH'(1);
      beat_cnt    <= '0;
      burst_cnt   <= '0;
      wait_cnt    <= '0;
      seed_q      <= '0;
      seen_busy   <= 1'b0;
      amode_q     <= 1'b0;
      lmode_q     <= 1'b0;
    end else begin
      WRITE    <= fire_wr;
      READ     <= fire_rd;
      wait_cnt <= progress ? '0 : wait_cnt + 16'd1;
      if (start_take) begin
        done        <= 1'b0;
        pass        <= 1'b0;
        timeout     <= 1'b0;
        error_count <= '0;
        burst_cnt   <= '0;
        seq_addr    <= '0;
        cyc_len     <= LEN_WIDTH'(1);
        amode_q     <= addr_mode;
        lmode_q     <= len_mode;
      end
      if (fire_wr) begin
        CPU_ADDR    <= amode_q ? (a_q & ~ADDRESS_WIDTH'(3)) : seq_addr;
        DATA_LENGTH <= lmode_q ? cyc_len : LEN_WIDTH'(MAX_LEN);
        DATA_IN     <= d_q;
        DATA_VALID  <= 1'b1;
        seed_q      <= d_q;
        beat_cnt    <= LEN_WIDTH'(1);
        seen_busy   <= 1'b0;
        seq_addr    <= seq_addr + ADDRESS_WIDTH'(MAX_LEN);
        cyc_len     <= (cyc_len == LEN_WIDTH'(MAX_LEN)) ?
                       LEN_WIDTH'(1) : cyc_len + LEN_WIDTH'(1);
      end
      if (wr_beat) begin
        DATA_IN  <= d_q;
        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      end
      if (state == WR_DATA && !wr_beat) begin
        DATA_VALID <= 1'b0;
        DATA_IN    <= '0;
      end
      if (state == WR_WAIT && BUSY) seen_busy <= 1'b1;
      if (fire_rd) beat_cnt <= '0;
      if (rd_beat) beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      if (mismatch && error_count != 16'hFFFF) begin
        error_count <= error_count + 16'd1;
      end
      if (pair_done) burst_cnt <= burst_cnt + 16'd1;
      if (to_hit) timeout <= 1'b1;
      if (state_nxt == DONE && state != DONE) begin
        done <= 1'b1;
        pass <= !to_hit && (error_count == 16'd0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_traffic_gen.sv
// Randomised loopback bench for axi4_lite_traffic_gen.
// A memory model answers reads; a burst-level model predicts strobes.
module tb_axi4_lite_traffic_gen;
  import axi4_lite_traffic_gen_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 5;
  localparam int ML = 16;
  localparam int NB = 6;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          addr_mode = 1'b0;
  logic          len_mode = 1'b0;
  logic          WRITE, READ, DATA_VALID;
  logic          done, pass, timeout;
  logic [AW-1:0] CPU_ADDR;
  logic [LW-1:0] DATA_LENGTH;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] DATA_OUT = '0;
  logic          OUT_VALID = 1'b0;
  logic          BUSY = 1'b0;
  logic [15:0]   error_count;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   m_data;
  logic [31:0]   m_addr;
  logic [31:0]   mem [int];

  always #5 clk = ~clk;

  axi4_lite_traffic_gen #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .MAX_LEN(ML), .NUM_BURSTS(NB), .TIMEOUT(TO)
  ) dut (
    .axi4_lite_aclk   (clk),
    .axi4_lite_aresetn(rst_n),
    .start            (start),
    .addr_mode        (addr_mode),
    .len_mode         (len_mode),
    .WRITE            (WRITE),
    .READ             (READ),
    .CPU_ADDR         (CPU_ADDR),
    .DATA_LENGTH      (DATA_LENGTH),
    .DATA_IN          (DATA_IN),
    .DATA_VALID       (DATA_VALID),
    .DATA_OUT         (DATA_OUT),
    .OUT_VALID        (OUT_VALID),
    .BUSY             (BUSY),
    .done             (done),
    .pass             (pass),
    .timeout          (timeout),
    .error_count      (error_count)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input bit am, input bit lm, input bit corrupt,
                        input bit stuck, input bit extra,
                        input int rst_beat);
    logic [31:0] q[$];
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] ea;
    logic [31:0] d;
    int wlen = 0, wbeat = 0, kw = 0, kr = 0;
    int busy_left = 0, cyc = 0, exp_err = 0, el = 0, n = 0;
    bit prev_dv = 1'b0, aborted = 1'b0;
    BUSY = 1'b0;
    OUT_VALID = 1'b0;
    @(negedge clk);
    addr_mode = am;
    len_mode = lm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && !aborted && cyc < 4000) begin
      if (WRITE) begin
        if (am) begin
          ea = m_addr & ~32'h3;
          m_addr = lfsr_step(m_addr);
        end else begin
          ea = AW'(kw * ML);
        end
        el = lm ? (kw % ML) + 1 : ML;
        check("wr_addr", CPU_ADDR, ea);
        check("wr_len", DATA_LENGTH, el);
        waddr = CPU_ADDR;
        wlen = int'(DATA_LENGTH);
        wbeat = 0;
        kw++;
        if (stuck) BUSY = 1'b1;
      end
      if (DATA_VALID) begin
        check("wr_data", DATA_IN, m_data);
        m_data = lfsr_step(m_data);
        mem[int'(waddr) + wbeat] = DATA_IN;
        if (wbeat == rst_beat) begin
          rst_n = 1'b0;
          aborted = 1'b1;
        end
        wbeat++;
      end else if (prev_dv) begin
        check("wr_tail", DATA_IN, 0);
        check("wr_beats", wbeat, wlen);
        if (!stuck) busy_left = $urandom_range(1, 3);
      end
      prev_dv = DATA_VALID;
      if (READ) begin
        check("rd_addr", CPU_ADDR, waddr);
        check("rd_len", DATA_LENGTH, wlen);
        q.delete();
        for (int i = 0; i < wlen; i++) begin
          d = mem[int'(waddr) + i];
          if (corrupt && kr == 1 && i == 3) begin
            d = d ^ 32'h1;
            exp_err++;
          end
          q.push_back(d);
        end
        if (extra) begin
          for (int i = 0; i < 3; i++) q.push_back($urandom);
        end
        kr++;
      end
      if (!stuck) begin
        BUSY = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end
      if (q.size() > 0 && ($urandom % 4) != 0) begin
        OUT_VALID = 1'b1;
        DATA_OUT = q.pop_front();
      end else begin
        OUT_VALID = 1'b0;
        DATA_OUT = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    OUT_VALID = 1'b0;
    BUSY = 1'b0;
    if (aborted) begin
      check("rst_dv", DATA_VALID, 0);
      check("rst_wr", WRITE, 0);
      check("rst_addr", CPU_ADDR, 0);
      check("rst_len", DATA_LENGTH, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      m_data = DATA_SEED;
      m_addr = ADDR_SEED;
      repeat (20) begin
        @(negedge clk);
        if (WRITE || READ || DATA_VALID) n++;
      end
      check("rst_quiet", n, 0);
    end else begin
      check("done", done, 1);
      check("timeout", timeout, stuck);
      check("err_cnt", error_count, exp_err);
      check("pass", pass, !stuck && exp_err == 0);
      check("bursts", kr, stuck ? 0 : NB);
      repeat (3) @(negedge clk);
      check("done_hold", done, 1);
    end
  endtask

  initial begin
    m_data = DATA_SEED;
    m_addr = ADDR_SEED;
    repeat (3) @(negedge clk);
    check("rst_write", WRITE, 0);
    check("rst_read", READ, 0);
    check("rst_valid", DATA_VALID, 0);
    check("rst_done0", done, 0);
    check("rst_pass", pass, 0);
    check("rst_tmo", timeout, 0);
    check("rst_cpu_addr", CPU_ADDR, 0);
    check("rst_data_in", DATA_IN, 0);
    check("rst_length", DATA_LENGTH, 0);
    check("rst_errors", error_count, 0);
    rst_n = 1'b1;
    do_run(0, 0, 0, 0, 0, -1);
    do_run(0, 1, 0, 0, 0, -1);
    do_run(1, 1, 0, 0, 0, -1);
    do_run(0, 0, 1, 0, 0, -1);
    do_run(1, 0, 0, 0, 1, -1);
    do_run(0, 0, 0, 1, 0, -1);
    do_run(1, 0, 0, 0, 0, -1);
    do_run(0, 0, 0, 0, 0, 5);
    do_run(0, 1, 0, 0, 1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
